// File: rtl/bdpsk_lut_sequencer_pkg.sv
// Shared constants, state encoding and address helper for the BDPSK LUT sequencer.
package bdpsk_pkg;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_AW    = 5;
  localparam logic [LUT_AW-1:0] HALF_TURN = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  // A 180 degree phase flip is a half-table offset; the 5-bit add wraps modulo 32.
  function automatic logic [LUT_AW-1:0] lut_addr_of(input logic [LUT_AW-1:0] phase,
                                                     input logic p);
    return phase + (p ? HALF_TURN : '0);
  endfunction
endpackage

// File: rtl/bdpsk_lut_sequencer_if.sv
// Bit-source handshake and LUT address stream of the BDPSK sequencer.
interface bdpsk_lut_sequencer_if;
  logic                          bit_in;
  logic                          bit_valid;
  logic                          bit_ready;
  logic [bdpsk_pkg::LUT_AW-1:0]  lut_addr;
  logic                          sample_valid;
  logic                          symbol_start;
  logic                          busy;
  logic                          burst_end;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, lut_addr, sample_valid, symbol_start, busy, burst_end
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, lut_addr, sample_valid, symbol_start, busy, burst_end
  );
endinterface

// File: rtl/bdpsk_lut_sequencer_strobe_div.sv
// Sample-rate divider: strobe_o is high once every SAMPLE_DIV cycles; load_i makes it fire next cycle.
module sample_strobe_div #(
  parameter int SAMPLE_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic strobe_o
);
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)               cnt_q <= '0;
    else if (load_i)         cnt_q <= LAST;
    else if (cnt_q == LAST)  cnt_q <= '0;
    else                     cnt_q <= cnt_q + CW'(1);
  end

  assign strobe_o = (cnt_q == LAST);
endmodule

// File: rtl/bdpsk_lut_sequencer.sv
// BDPSK LUT address sequencer with differential encoding and programmable sample rate.
// Optional reference-symbol preamble per burst: define BDPSK_SEQ_PREAMBLE_EN.
module bdpsk_lut_sequencer
  import bdpsk_pkg::*;
#(
  parameter int CARRIERS_PER_SYMBOL = 4,
  parameter int SAMPLE_DIV          = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bdpsk_lut_sequencer_if.slave  seq
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
`ifdef BDPSK_SEQ_PREAMBLE_EN
  localparam logic [1:0] PRE  = ST_PRE;
`endif
  localparam logic [LUT_AW-1:0] PHASE_LAST = LUT_AW'(LUT_DEPTH - 1);
  localparam logic [7:0]        CAR_LAST   = 8'(CARRIERS_PER_SYMBOL - 1);

  logic [1:0]        state_q, state_d;
  logic              p_q, p_d;
  logic [LUT_AW-1:0] phase_q, phase_d;
  logic [LUT_AW-1:0] addr_q, addr_d;
  logic [7:0]        car_q, car_d;
  logic              burst_end_q, burst_end_d;
`ifdef BDPSK_SEQ_PREAMBLE_EN
  logic              bit_q, bit_d;
`endif
  logic              strobe, load, active, last_sample, xfer;

  sample_strobe_div #(.SAMPLE_DIV(SAMPLE_DIV)) u_div (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (load),
    .strobe_o (strobe)
  );

  // phase_q/car_q describe the sample currently shown on lut_addr, so the
  // strobe cycle is the cycle that sample is valid.
  assign active        = (state_q != IDLE);
  assign last_sample   = active && strobe && (phase_q == PHASE_LAST) && (car_q == CAR_LAST);
  assign seq.bit_ready = (state_q == IDLE) || ((state_q == RUN) && last_sample);
  assign xfer          = seq.bit_valid && seq.bit_ready;
  assign load          = (state_q == IDLE) && xfer;

  assign seq.lut_addr     = addr_q;
  assign seq.sample_valid = active && strobe;
  assign seq.symbol_start = active && strobe && (phase_q == '0) && (car_q == '0);
  assign seq.busy         = active;
  assign seq.burst_end    = burst_end_q;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    phase_d     = phase_q;
    car_d       = car_q;
    addr_d      = addr_q;
    burst_end_d = 1'b0;
`ifdef BDPSK_SEQ_PREAMBLE_EN
    bit_d       = bit_q;
`endif
    if (state_q == IDLE) begin
      if (xfer) begin
        phase_d = '0;
        car_d   = '0;
`ifdef BDPSK_SEQ_PREAMBLE_EN
        bit_d   = seq.bit_in;
        p_d     = 1'b0;
        state_d = PRE;
`else
        p_d     = seq.bit_in;
        state_d = RUN;
`endif
        addr_d  = lut_addr_of('0, p_d);
      end
    end else if (strobe) begin
      if (last_sample) begin
        phase_d = '0;
        car_d   = '0;
`ifdef BDPSK_SEQ_PREAMBLE_EN
        if (state_q == PRE) begin
          p_d     = p_q ^ bit_q;
          state_d = RUN;
        end else
`endif
        if (xfer) begin
          p_d = p_q ^ seq.bit_in;
        end else begin
          state_d     = IDLE;
          burst_end_d = 1'b1;
        end
        // Going idle keeps the last address on the bus.
        if (state_d != IDLE) addr_d = lut_addr_of('0, p_d);
      end else begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          car_d   = car_q + 8'd1;
        end else begin
          phase_d = phase_q + LUT_AW'(1);
        end
        addr_d = lut_addr_of(phase_d, p_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      p_q         <= 1'b0;
      phase_q     <= '0;
      car_q       <= '0;
      addr_q      <= '0;
      burst_end_q <= 1'b0;
`ifdef BDPSK_SEQ_PREAMBLE_EN
      bit_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      phase_q     <= phase_d;
      car_q       <= car_d;
      addr_q      <= addr_d;
      burst_end_q <= burst_end_d;
`ifdef BDPSK_SEQ_PREAMBLE_EN
      bit_q       <= bit_d;
`endif
    end
  end
endmodule

// File: doc/bdpsk_lut_sequencer.md
# bdpsk_lut_sequencer

Sequences the 32-entry sine lookup table of the BDPSK modulator. It accepts data bits over a valid/ready handshake and differentially encodes them, so a `1` flips the carrier phase by 180° and a `0` keeps it. It then emits a registered 5-bit LUT address stream at a programmable sample rate, with a strobe marking each valid sample. It sits between the bit source (framer/FIFO) and the LUT; the LUT `dataout` feeds the DAC path.

## Interface
- `CARRIERS_PER_SYMBOL`, default 4: full carrier periods (32 samples each) per data symbol, 1..255.
- `SAMPLE_DIV`, default 1: clock cycles per LUT sample, 1..65535. 1 advances the address every cycle.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bit_in`  in  1  data bit, qualified by `bit_valid`.
- `bit_valid`  in  1  source has a bit.
- `bit_ready`  out  1  sequencer accepts `bit_in` this cycle. Transfer happens when `bit_valid && bit_ready`.
- `lut_addr`  out  5  LUT address, registered.
- `sample_valid`  out  1  `lut_addr` holds a new sample this cycle (1-cycle pulse per sample).
- `symbol_start`  out  1  pulses with the first sample of each symbol.
- `busy`  out  1  state ≠ IDLE.
- `burst_end`  out  1  1-cycle pulse when the last symbol finishes with no follow-on bit.

## Operation
- FSM states: IDLE, PRE (only when the macro is enabled), RUN.
- **IDLE**
  - `bit_ready`=1.
  - On transfer: phase register `p`←0 and store `bit_in`, then go to RUN (or to PRE with the macro enabled).
  - `lut_addr` holds its last value; `sample_valid`=0.
- **Differential encode:** when a symbol begins with stored bit b, `p ← p ^ b`.
- **Address:** `lut_addr = (phase_cnt + (p ? 16 : 0)) mod 32`.
  - 5-bit wrap, no saturation.
  - `phase_cnt` counts 0..31, then wraps and increments `carrier_cnt`.
  - `carrier_cnt` counts 0..CARRIERS_PER_SYMBOL-1.
- **Sample strobe:** `div_cnt` counts 0..SAMPLE_DIV-1. A strobe fires when `div_cnt == SAMPLE_DIV-1`. With SAMPLE_DIV=1 the strobe is high every cycle.
- **Last-sample cycle:** strobe with `phase_cnt==31` and `carrier_cnt==CARRIERS_PER_SYMBOL-1`.
  - In RUN, `bit_ready`=1 only in this cycle. It is combinational from state and counters, and never depends on `bit_valid`.
  - Transfer in this cycle: the next symbol starts on the next strobe with no gap. Counters wrap to 0, `p` updates, `symbol_start` pulses.
  - No transfer: go to IDLE, `burst_end` pulses the following cycle, and `p` is kept.
- **Reset mid-symbol:** outputs and state return to reset values immediately. The in-flight bit is discarded.
- **Reset values:**
  - `lut_addr`=0, `sample_valid`=0, `symbol_start`=0, `busy`=0, `burst_end`=0.
  - State IDLE, so `bit_ready`=1.
  - `p`=0, all counters 0.

## Timing
- Transfer in IDLE at cycle T:
  - First sample: `sample_valid`=1, `symbol_start`=1, `lut_addr` = (b ? 16 : 0), registered at T+1.
  - This holds regardless of SAMPLE_DIV. `div_cnt` is preset so the first strobe lands on T+1.
- Samples then repeat every SAMPLE_DIV cycles.
- Symbol length is exactly 32·CARRIERS_PER_SYMBOL·SAMPLE_DIV cycles.
- Back-to-back symbols have no gap or repeated sample.
- LUT read is combinational, so LUT data aligns with `lut_addr` and `sample_valid` in the same cycle.

## Configuration
- `BDPSK_SEQ_PREAMBLE_EN`
  - **Defined:** each burst (transfer from IDLE) first emits one reference symbol with `p`=0 in state PRE. `symbol_start` pulses at its first sample and `bit_ready`=0 throughout. The stored bit is then applied in RUN, giving the receiver a phase reference.
  - **Undefined:** PRE does not exist; IDLE goes directly to RUN.

## Structure
- Package `bdpsk_pkg`:
  - State enum type.
  - `LUT_DEPTH`=32, `LUT_AW`=5, `HALF_TURN`=16.
- Sub-module `sample_strobe_div`: parameter SAMPLE_DIV, `load` input (preset to fire next cycle), `strobe` output.

## Test plan
- Reset, then send bit 0 with CARRIERS=1, DIV=1 → addresses 0,1,…,31 on 32 consecutive cycles. `symbol_start` on the first, then `burst_end` and `busy`=0.
- Bits 1,1,0 back-to-back (CARRIERS=1, DIV=1):
  - Addresses 16..31,0..15, then 0..31, then 0..31.
  - `bit_ready` high only at each address-15, address-31 and address-31 sample respectively.
  - 96 strobes, no gaps.
- DIV=3, bit 1 → `lut_addr` steps every 3 cycles starting at 16. `sample_valid` is high 1 cycle in 3. Symbol lasts 96 cycles.
- `bit_valid` held low at the last sample → IDLE, `burst_end` pulse. Next bit 1 → `p` resets, first address 16.
- Assert `reset` at `phase_cnt`=10 → all outputs reach reset values asynchronously. `bit_ready`=1 after release.
- With `BDPSK_SEQ_PREAMBLE_EN`, bit 1 → 32 samples starting at address 0 with `bit_ready`=0, then 32 samples starting at address 16. `symbol_start` pulses twice.
